// File: rtl/mvm_operand_feeder.sv
// rtl/mvm_operand_feeder.sv - issues weight/data buffer reads in MVM loop order and forwards returns as beats
module mvm_operand_feeder #(
    parameter int DW     = 8,
    parameter int TIN    = 8,
    parameter int TOUT   = 8,
    parameter int H_W    = 8,
    parameter int W_W    = 6,
    parameter int AW     = 16,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [H_W-1:0]    height,
    input  logic [W_W-1:0]    Win_div_Tin,
    input  logic [W_W-1:0]    Wout_div_Tout,
    input  logic [AW-1:0]     dat_base,
    input  logic [AW-1:0]     wt_base,
    input  logic              stall,
    output logic              dat_rd_en,
    output logic [AW-1:0]     dat_rd_addr,
    input  logic [DW*TIN-1:0] dat_rd_data,
    output logic              wt_rd_en,
    output logic [AW-1:0]     wt_rd_addr,
    input  logic [DW*TIN-1:0] wt_rd_data,
    output logic              dat_vld,
    output logic [DW*TIN-1:0] o_dat,
    output logic              wt_vld,
    output logic [DW*TIN-1:0] o_wt,
    output logic              busy,
    output logic              done
);
    localparam int KW = (TOUT > 1) ? $clog2(TOUT) : 1;
    localparam int LW = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_WT,
        S_ST_DAT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [H_W-1:0] height_q;
    logic [W_W-1:0] win_q;
    logic [W_W-1:0] wout_q;
    logic [AW-1:0]  dat_base_q;
    logic [KW-1:0]  k_cnt;
    logic [H_W-1:0] h_cnt;
    logic [W_W-1:0] wi_cnt;
    logic [W_W-1:0] wo_cnt;
    logic [AW-1:0]  wt_ptr;
    logic [AW-1:0]  dat_ptr;
    logic [AW-1:0]  dat_col;
    logic [LW-1:0]  drain_cnt;

    logic wt_issue, dat_issue;
    logic last_k, last_h, last_wi, last_wo, dims_zero;

    assign wt_issue  = (state == S_LD_WT) && !stall;
    assign dat_issue = (state == S_ST_DAT) && !stall;
    assign last_k    = (k_cnt == KW'(TOUT - 1));
    assign last_h    = (h_cnt == height_q - H_W'(1));
    assign last_wi   = (wi_cnt == win_q - W_W'(1));
    assign last_wo   = (wo_cnt == wout_q - W_W'(1));
    assign dims_zero = (height == '0) || (Win_div_Tin == '0) || (Wout_div_Tout == '0);

    assign wt_rd_en    = wt_issue;
    assign wt_rd_addr  = wt_issue ? wt_ptr : '0;
    assign dat_rd_en   = dat_issue;
    assign dat_rd_addr = dat_issue ? dat_ptr : '0;
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (start) state_n = dims_zero ? S_DONE : S_LD_WT;
            S_LD_WT:  if (wt_issue && last_k) state_n = S_ST_DAT;
            S_ST_DAT: if (dat_issue && last_h) state_n = (last_wi && last_wo) ? S_DRAIN : S_LD_WT;
            S_DRAIN:  if (drain_cnt == LW'(RD_LAT)) state_n = S_DONE;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Weights are laid out chunk after chunk, so a single running pointer covers every (wo, wi, k).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            height_q   <= '0;
            win_q      <= '0;
            wout_q     <= '0;
            dat_base_q <= '0;
            k_cnt      <= '0;
            h_cnt      <= '0;
            wi_cnt     <= '0;
            wo_cnt     <= '0;
            wt_ptr     <= '0;
            dat_ptr    <= '0;
            dat_col    <= '0;
            drain_cnt  <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                height_q   <= height;
                win_q      <= Win_div_Tin;
                wout_q     <= Wout_div_Tout;
                dat_base_q <= dat_base;
                k_cnt      <= '0;
                h_cnt      <= '0;
                wi_cnt     <= '0;
                wo_cnt     <= '0;
                wt_ptr     <= wt_base;
                dat_ptr    <= dat_base;
                dat_col    <= dat_base;
                drain_cnt  <= '0;
            end
            if (wt_issue) begin
                wt_ptr <= wt_ptr + AW'(1);
                k_cnt  <= last_k ? '0 : k_cnt + KW'(1);
            end
            // Data rows of one input chunk are Win_div_Tin words apart; dat_col marks the chunk column.
            if (dat_issue) begin
                if (last_h) begin
                    h_cnt <= '0;
                    if (last_wi) begin
                        wi_cnt  <= '0;
                        wo_cnt  <= wo_cnt + W_W'(1);
                        dat_col <= dat_base_q;
                        dat_ptr <= dat_base_q;
                    end else begin
                        wi_cnt  <= wi_cnt + W_W'(1);
                        dat_col <= dat_col + AW'(1);
                        dat_ptr <= dat_col + AW'(1);
                    end
                end else begin
                    h_cnt   <= h_cnt + H_W'(1);
                    dat_ptr <= dat_ptr + AW'(win_q);
                end
            end
            if (state == S_DRAIN) begin
                drain_cnt <= drain_cnt + LW'(1);
            end
        end
    end

    logic [RD_LAT-1:0] wt_pipe, dat_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt_pipe  <= '0;
            dat_pipe <= '0;
            wt_vld   <= 1'b0;
            dat_vld  <= 1'b0;
            o_wt     <= '0;
            o_dat    <= '0;
        end else begin
            wt_pipe  <= (wt_pipe << 1) | RD_LAT'(wt_rd_en);
            dat_pipe <= (dat_pipe << 1) | RD_LAT'(dat_rd_en);
            wt_vld   <= wt_pipe[RD_LAT-1];
            dat_vld  <= dat_pipe[RD_LAT-1];
            if (wt_pipe[RD_LAT-1]) o_wt <= wt_rd_data;
            if (dat_pipe[RD_LAT-1]) o_dat <= dat_rd_data;
        end
    end
endmodule

// File: tb/tb_mvm_operand_feeder.sv
// tb/tb_mvm_operand_feeder.sv - scoreboard bench for mvm_operand_feeder
module tb_mvm_operand_feeder;
    localparam int TOUT   = 8;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  height = '0;
    logic [5:0]  win = '0;
    logic [5:0]  wout = '0;
    logic [15:0] dat_base = '0;
    logic [15:0] wt_base = '0;
    logic        stall = 1'b0;
    logic        dat_rd_en, wt_rd_en, dat_vld, wt_vld, busy, done;
    logic [15:0] dat_rd_addr, wt_rd_addr;
    logic [63:0] dat_rd_data, wt_rd_data, o_dat, o_wt;

    mvm_operand_feeder #(.TOUT(TOUT), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .height(height),
        .Win_div_Tin(win), .Wout_div_Tout(wout), .dat_base(dat_base), .wt_base(wt_base),
        .stall(stall), .dat_rd_en(dat_rd_en), .dat_rd_addr(dat_rd_addr), .dat_rd_data(dat_rd_data),
        .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr), .wt_rd_data(wt_rd_data),
        .dat_vld(dat_vld), .o_dat(o_dat), .wt_vld(wt_vld), .o_wt(o_wt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] wt_word(input logic [15:0] a);
        return {16'hBEEF, a, 16'h1234, ~a};
    endfunction

    function automatic logic [63:0] dat_word(input logic [15:0] a);
        return {16'hDA7A, ~a, a, 16'h5678};
    endfunction

    // buffer model: fixed read latency, junk when no read is returning
    logic        we_d [RD_LAT];
    logic        de_d [RD_LAT];
    logic [15:0] wa_d [RD_LAT];
    logic [15:0] da_d [RD_LAT];

    always @(posedge clk) begin
        we_d[0] <= wt_rd_en;
        de_d[0] <= dat_rd_en;
        wa_d[0] <= wt_rd_addr;
        da_d[0] <= dat_rd_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            we_d[i] <= we_d[i-1];
            de_d[i] <= de_d[i-1];
            wa_d[i] <= wa_d[i-1];
            da_d[i] <= da_d[i-1];
        end
    end

    assign wt_rd_data  = we_d[RD_LAT-1] ? wt_word(wa_d[RD_LAT-1]) : 64'hDEAD_DEAD_DEAD_DEAD;
    assign dat_rd_data = de_d[RD_LAT-1] ? dat_word(da_d[RD_LAT-1]) : 64'hDEAD_DEAD_DEAD_DEAD;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [16:0] rd_q[$];
    logic [64:0] beat_q[$];

    int cyc = 0;
    int rd_n = 0, wt_vld_n = 0, dat_vld_n = 0, busy_n = 0, done_n = 0;
    int first_rd = -1, first_vld = -1, last_vld = 0, done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (start && !busy) begin
                first_rd  <= -1;
                first_vld <= -1;
            end
            if (wt_rd_en && dat_rd_en) check("rd_excl", 1, 0);
            if (wt_vld && dat_vld) check("vld_excl", 1, 0);
            if (wt_rd_en || dat_rd_en) begin
                rd_n <= rd_n + 1;
                if (first_rd < 0) first_rd <= cyc;
                if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
                else check("rd_addr", {wt_rd_en, wt_rd_en ? wt_rd_addr : dat_rd_addr}, rd_q.pop_front());
            end
            if (wt_vld || dat_vld) begin
                if (wt_vld) wt_vld_n <= wt_vld_n + 1;
                else dat_vld_n <= dat_vld_n + 1;
                if (first_vld < 0) first_vld <= cyc;
                last_vld <= cyc;
                if (beat_q.size() == 0) check("beat_unexpected", 1, 0);
                else check("beat", {wt_vld, wt_vld ? o_wt : o_dat}, beat_q.pop_front());
            end
            if (busy) busy_n <= busy_n + 1;
            if (done) begin
                done_n   <= done_n + 1;
                done_cyc <= cyc;
            end
        end
    end

    task automatic push_job(input int h, input int wi_n, input int wo_n, input logic [15:0] db, input logic [15:0] wb);
        logic [15:0] a;
        for (int wo = 0; wo < wo_n; wo++) begin
            for (int wi = 0; wi < wi_n; wi++) begin
                for (int k = 0; k < TOUT; k++) begin
                    a = wb + 16'((wo * wi_n + wi) * TOUT + k);
                    rd_q.push_back({1'b1, a});
                    beat_q.push_back({1'b1, wt_word(a)});
                end
                for (int hh = 0; hh < h; hh++) begin
                    a = db + 16'(hh * wi_n + wi);
                    rd_q.push_back({1'b0, a});
                    beat_q.push_back({1'b0, dat_word(a)});
                end
            end
        end
    endtask

    task automatic pulse_start(input int h, input int wi_n, input int wo_n, input logic [15:0] db, input logic [15:0] wb);
        height   = 8'(h);
        win      = 6'(wi_n);
        wout     = 6'(wo_n);
        dat_base = db;
        wt_base  = wb;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        height   = 8'hFF;
        win      = 6'h3F;
        wout     = 6'h3F;
        dat_base = 16'hAAAA;
        wt_base  = 16'h5555;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    // mode 0 plain, 1 ignored second start mid-job, 2 stall window on first data read
    task automatic run_job(input int h, input int wi_n, input int wo_n, input logic [15:0] db, input logic [15:0] wb,
                           input int mode);
        int wt0, dat0, done0, rd0, vld0, n;
        wt0 = wt_vld_n; dat0 = dat_vld_n; done0 = done_n;
        push_job(h, wi_n, wo_n, db, wb);
        pulse_start(h, wi_n, wo_n, db, wb);
        if (mode == 1) begin
            repeat (5) @(posedge clk);
            #1;
            pulse_start(1, 1, 1, 16'h0777, 16'h0888);
        end
        if (mode == 2) begin
            n = 0;
            while (!dat_rd_en && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("stall_seen_dat", dat_rd_en, 1);
            @(posedge clk);
            #1;
            rd0 = rd_n; vld0 = wt_vld_n + dat_vld_n;
            stall = 1'b1;
            repeat (4) @(posedge clk);
            #1;
            check("stall_no_rd", rd_n - rd0, 0);
            check("stall_inflight", wt_vld_n + dat_vld_n - vld0, RD_LAT + 1);
            stall = 1'b0;
        end
        wait_done(3000);
        check("rd_q_empty", rd_q.size(), 0);
        check("beat_q_empty", beat_q.size(), 0);
        check("wt_total", wt_vld_n - wt0, wo_n * wi_n * TOUT);
        check("dat_total", dat_vld_n - dat0, wo_n * wi_n * h);
        check("done_once", done_n - done0, 1);
        check("idle_after", {busy, done}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int busy0, done0, rd0, vld0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {busy, done, wt_vld, dat_vld, wt_rd_en, dat_rd_en, wt_rd_addr, dat_rd_addr}, 0);
        check("reset_data", {o_wt, o_dat} == 128'd0, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1 single chunk timing
        run_job(3, 1, 1, 16'h0100, 16'h0200, 0);
        check("t1_latency", first_vld - first_rd, RD_LAT + 1);
        check("t1_contiguous", last_vld - first_vld, TOUT + 3 - 1);
        check("t1_done_gap", done_cyc - last_vld, 1);

        // T2 multi-chunk, with an ignored start while busy
        run_job(2, 2, 2, 16'h0100, 16'h0000, 1);

        // T3 stall mid data phase
        run_job(6, 1, 1, 16'h0300, 16'h0400, 2);

        // T4 zero dimension
        busy0 = busy_n; done0 = done_n; rd0 = rd_n; vld0 = wt_vld_n + dat_vld_n;
        pulse_start(0, 2, 2, 16'h0100, 16'h0200);
        wait_done(20);
        check("t4_no_rd", rd_n - rd0, 0);
        check("t4_no_vld", wt_vld_n + dat_vld_n - vld0, 0);
        check("t4_busy_1cyc", busy_n - busy0, 1);
        check("t4_done", done_n - done0, 1);

        // T5 async reset during weight loading
        done0 = done_n;
        push_job(3, 2, 1, 16'h0100, 16'h0200);
        pulse_start(3, 2, 1, 16'h0100, 16'h0200);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        rd_q.delete();
        beat_q.delete();
        #1;
        check("t5_async_outs", {busy, done, wt_vld, dat_vld, wt_rd_en, dat_rd_en}, 0);
        check("t5_async_data", {o_wt, o_dat} == 128'd0, 1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("t5_no_done", done_n - done0, 0);
        run_job(3, 2, 1, 16'h0100, 16'h0200, 0);

        // T6 address wrap
        run_job(2, 1, 1, 16'hFFFF, 16'hFFFE, 0);

        // wider mix
        run_job(1, 3, 2, 16'h1234, 16'h8000, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
